// File: rtl/serial_subtractor_if.sv
// Operand/result handshake bundle for the bit-serial subtractor.
// The slave side is the subtractor; the master side is the operand
// source combined with the result consumer.
interface serial_subtractor_if #(
    parameter int WIDTH = 8
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             bin;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] diff;
    logic             bout;

    modport slave (
        input  in_valid, a, b, bin, out_ready,
        output in_ready, out_valid, diff, bout
    );

    modport master (
        output in_valid, a, b, bin, out_ready,
        input  in_ready, out_valid, diff, bout
    );
endinterface

// File: rtl/serial_subtractor.sv
// Bit-serial unsigned subtractor: a - b - bin, LSB first, one bit per
// clock through a single full-subtractor cell with a registered borrow.
// Operands are accepted in IDLE, WIDTH cycles are spent in RUN, and the
// result is held in DONE until the consumer takes it.
module serial_subtractor #(
    parameter int WIDTH = 8
) (
    input  logic                clk,
    input  logic                rst_n,
    serial_subtractor_if.slave  bus
);
    localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state;
    state_t           state_next;
    logic [WIDTH-1:0] a_sr;
    logic [WIDTH-1:0] b_sr;
    logic [WIDTH-1:0] diff_sr;
    logic [WIDTH-1:0] diff_shifted;
    logic [CNT_W-1:0] cnt;
    logic             br;
    logic             a0;
    logic             b0;
    logic             d;
    logic             br_next;
    logic             last_bit;

    // Full-subtractor cell on the current LSBs and the registered borrow.
    assign a0      = a_sr[0];
    assign b0      = b_sr[0];
    assign d       = a0 ^ b0 ^ br;
    assign br_next = (~a0 & b0) | (~(a0 ^ b0) & br);

    // New difference bit enters at the MSB; written as a shift-or so that
    // it also covers WIDTH = 1, where the result is just d.
    assign diff_shifted = (diff_sr >> 1) | (WIDTH'(d) << (WIDTH - 1));
    assign last_bit     = (cnt == CNT_LAST);

    // State register.
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state decode.
    // NOTE: the default assignment first keeps this block free of latches
    // for any state/input combination the case does not mention.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (bus.in_valid) state_next = RUN;
            RUN:     if (last_bit)     state_next = DONE;
            DONE:    if (bus.out_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Datapath: load on accept, shift one bit per RUN cycle, hold otherwise.
    // NOTE: every datapath register is reset here so diff/bout read as zero
    // immediately after reset, even though they are only meaningful in DONE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_sr    <= '0;
            b_sr    <= '0;
            diff_sr <= '0;
            cnt     <= '0;
            br      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.in_valid) begin
                        a_sr    <= bus.a;
                        b_sr    <= bus.b;
                        br      <= bus.bin;
                        diff_sr <= '0;
                        cnt     <= '0;
                    end
                end
                RUN: begin
                    a_sr    <= a_sr >> 1;
                    b_sr    <= b_sr >> 1;
                    br      <= br_next;
                    diff_sr <= diff_shifted;
                    cnt     <= cnt + CNT_W'(1);
                end
                default: ;
            endcase
        end
    end

    // Handshake flags come straight from the registered state.
    assign bus.in_ready  = (state == IDLE);
    assign bus.out_valid = (state == DONE);
    assign bus.diff      = diff_sr;
    assign bus.bout      = br;
endmodule

// File: tb/tb_serial_subtractor.sv
// Directed and random checks of serial_subtractor at WIDTH = 8, plus an
// exhaustive sweep of a WIDTH = 1 instance sharing the same clock/reset.
module tb_serial_subtractor;
    localparam int W = 8;

    logic clk;
    logic rst_n;
    int   n_tests;
    int   n_fail;

    serial_subtractor_if #(.WIDTH(W)) bus ();
    serial_subtractor_if #(.WIDTH(1)) bus1 ();

    serial_subtractor #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    serial_subtractor #(.WIDTH(1)) dut1 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus1.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One full transaction on the 8-bit instance. stall > 0 holds out_ready
    // low for that many DONE cycles while offering different operands.
    task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic bin,
                         input int stall, input bit chk_latency);
        logic [W:0]   full;
        logic [W-1:0] exp_diff;
        logic         exp_bout;
        int           w;
        int           cycles;
        full     = {1'b0, a} - {1'b0, b} - {{W{1'b0}}, bin};
        exp_diff = full[W-1:0];
        exp_bout = full[W];

        w = 0;
        while (!bus.in_ready && w < 50) begin
            tick();
            w++;
        end
        if (w >= 50) check("in_ready_timeout", 64'd0, 64'd1);

        bus.in_valid  = 1'b1;
        bus.a         = a;
        bus.b         = b;
        bus.bin       = bin;
        bus.out_ready = (stall == 0);
        tick();
        bus.in_valid = 1'b0;
        bus.a        = ~a;
        bus.b        = ~b;

        cycles = 0;
        while (!bus.out_valid && cycles < 100) begin
            tick();
            cycles++;
        end
        if (chk_latency || cycles >= 100) check("latency", 64'(cycles), 64'(W));
        check("diff", 64'(bus.diff), 64'(exp_diff));
        check("bout", 64'(bus.bout), 64'(exp_bout));

        for (int i = 0; i < stall; i++) begin
            bus.in_valid = 1'b1;
            bus.a        = a ^ 8'h5C;
            bus.b        = b ^ 8'h3A;
            bus.bin      = ~bin;
            tick();
            check("stall_out_valid", 64'(bus.out_valid), 64'd1);
            check("stall_in_ready", 64'(bus.in_ready), 64'd0);
            check("stall_diff", 64'(bus.diff), 64'(exp_diff));
            check("stall_bout", 64'(bus.bout), 64'(exp_bout));
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        tick();
        check("consumed_out_valid", 64'(bus.out_valid), 64'd0);
        check("consumed_in_ready", 64'(bus.in_ready), 64'd1);
    endtask

    initial begin
        bit seen;
        int cycles;
        logic [1:0] full1;

        n_tests = 0;
        n_fail  = 0;
        rst_n   = 1'b0;
        bus.in_valid   = 1'b0;
        bus.a          = '0;
        bus.b          = '0;
        bus.bin        = 1'b0;
        bus.out_ready  = 1'b0;
        bus1.in_valid  = 1'b0;
        bus1.a         = '0;
        bus1.b         = '0;
        bus1.bin       = 1'b0;
        bus1.out_ready = 1'b1;

        // Reset with random activity on the inputs.
        for (int i = 0; i < 4; i++) begin
            bus.in_valid  = 1'($urandom);
            bus.a         = 8'($urandom);
            bus.b         = 8'($urandom);
            bus.bin       = 1'($urandom);
            bus.out_ready = 1'($urandom);
            tick();
        end
        check("rst_in_ready", 64'(bus.in_ready), 64'd1);
        check("rst_out_valid", 64'(bus.out_valid), 64'd0);
        check("rst_diff", 64'(bus.diff), 64'h00);
        check("rst_bout", 64'(bus.bout), 64'd0);
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        rst_n         = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (bus.out_valid) seen = 1'b1;
        end
        check("idle_no_out_valid", 64'(seen), 64'd0);

        // Basic operation, latency and the borrow corner cases.
        do_op(8'h5A, 8'h23, 1'b0, 0, 1'b1);
        do_op(8'h00, 8'h01, 1'b0, 0, 1'b1);
        do_op(8'h10, 8'h10, 1'b1, 0, 1'b1);
        do_op(8'hFF, 8'h00, 1'b1, 0, 1'b1);

        // Backpressure for five DONE cycles.
        do_op(8'hC3, 8'h3C, 1'b0, 5, 1'b1);

        // Reset three cycles into RUN.
        bus.in_valid = 1'b1;
        bus.a        = 8'hA5;
        bus.b        = 8'h0F;
        bus.bin      = 1'b1;
        tick();
        bus.in_valid = 1'b0;
        tick();
        tick();
        tick();
        rst_n = 1'b0;
        #1;
        check("midrst_in_ready", 64'(bus.in_ready), 64'd1);
        check("midrst_out_valid", 64'(bus.out_valid), 64'd0);
        check("midrst_diff", 64'(bus.diff), 64'h00);
        check("midrst_bout", 64'(bus.bout), 64'd0);
        tick();
        rst_n = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (bus.out_valid) seen = 1'b1;
        end
        check("midrst_no_out_valid", 64'(seen), 64'd0);
        do_op(8'h80, 8'h01, 1'b0, 0, 1'b1);

        // Random back-to-back operations with random stalls.
        for (int i = 0; i < 1000; i++) begin
            do_op(8'($urandom), 8'($urandom), 1'($urandom), int'($urandom_range(0, 3)), 1'b0);
        end

        // WIDTH = 1 instance: all eight input combinations, latency 1.
        for (int i = 0; i < 8; i++) begin
            full1 = {1'b0, i[2]} - {1'b0, i[1]} - {1'b0, i[0]};
            bus1.in_valid = 1'b1;
            bus1.a        = i[2];
            bus1.b        = i[1];
            bus1.bin      = i[0];
            tick();
            bus1.in_valid = 1'b0;
            cycles = 0;
            while (!bus1.out_valid && cycles < 20) begin
                tick();
                cycles++;
            end
            check("w1_latency", 64'(cycles), 64'd1);
            check("w1_diff", 64'(bus1.diff), 64'(full1[0]));
            check("w1_bout", 64'(bus1.bout), 64'(full1[1]));
            tick();
            check("w1_in_ready", 64'(bus1.in_ready), 64'd1);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
